// File: rtl/bcd_convert_sched.sv
// bcd_convert_sched: one sequential double-dabble binary-to-BCD engine shared
// round-robin among NREQ requesters. Each 7-bit value takes 7 shift cycles and
// is returned as tens/ones with a one-cycle one-hot ack.
// Optional feature: define BCD_CLAMP_EN to clamp values above 99 to 99 at
// grant time and flag the clamp on ovf together with ack.
module bcd_convert_sched #(
    parameter int NREQ = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*7-1:0]         bin_in,
    output logic [NREQ-1:0]           ack,
    output logic [3:0]                ones,
    output logic [3:0]                tens,
    output logic [$clog2(NREQ)-1:0]   gnt_id,
    output logic                      busy,
    output logic                      ovf
);
    localparam int IDW   = $clog2(NREQ);
    localparam int BIN_W = 7;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state, state_nx;
    logic [IDW-1:0]     last_gnt;
    logic [IDW-1:0]     sel;
    logic               sel_vld;
    logic [2:0]         cnt;
    logic [BIN_W-1:0]   raw_val;
    logic [BIN_W-1:0]   grant_val;
    logic [BIN_W-1:0]   sh_bin;
    // Accumulator bit 7 can only become set on the final shift, so the stored
    // copy keeps 7 bits and the full 8-bit result comes from bcd_nx.
    logic [6:0]         bcd;
    logic [7:0]         bcd_nx;

    // Add-3 correction for one BCD digit; digit is at most 9 so no carry out.
    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d > 4'd4) ? d + 4'd3 : d;
    endfunction

    // Round-robin pick: first active request after the last granted one.
    always_comb begin
        int idx;
        sel     = '0;
        sel_vld = 1'b0;
        idx     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(last_gnt) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!sel_vld && req[idx]) begin
                sel_vld = 1'b1;
                sel     = IDW'(idx);
            end
        end
    end

    assign raw_val = bin_in[int'(sel)*BIN_W +: BIN_W];

    // One double-dabble step. Only the ones digit is corrected: for inputs up
    // to 99 the tens digit never exceeds 4 before a shift, and for 100..127 it
    // must stay a plain binary count so that tens reads 10..12.
    assign bcd_nx = {bcd[6:4], add3(bcd[3:0]), sh_bin[BIN_W-1]};

    // Next-state logic for the IDLE -> SHIFT -> DONE -> IDLE sequence.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (sel_vld) state_nx = SHIFT;
            SHIFT:   if (cnt == 3'd6) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Control and visible result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            last_gnt <= IDW'(NREQ - 1);
            gnt_id   <= '0;
            ack      <= '0;
            ones     <= 4'd0;
            tens     <= 4'd0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        gnt_id   <= sel;
                        last_gnt <= sel;
                        cnt      <= 3'd0;
                    end
                end
                SHIFT: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd6) begin
                        tens <= bcd_nx[7:4];
                        ones <= bcd_nx[3:0];
                        ack  <= NREQ'(1) << gnt_id;
                    end
                end
                DONE:    ack <= '0;
                default: ack <= '0;
            endcase
        end
    end

    // Shift datapath: load at grant, one shift per SHIFT cycle.
    always_ff @(posedge clk) begin
        if (state == IDLE && sel_vld) begin
            sh_bin <= grant_val;
            bcd    <= 7'd0;
        end else if (state == SHIFT) begin
            sh_bin <= {sh_bin[BIN_W-2:0], 1'b0};
            bcd    <= bcd_nx[6:0];
        end
    end

`ifdef BCD_CLAMP_EN
    logic clamp_hit;
    logic ovf_pend;

    // Saturate the captured value to the two-digit range.
    function automatic logic [BIN_W-1:0] clamp99(input logic [BIN_W-1:0] v);
        return (v > 7'd99) ? 7'd99 : v;
    endfunction

    assign grant_val = clamp99(raw_val);
    assign clamp_hit = (raw_val > 7'd99);

    // Remember a clamp at grant and report it only during DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_pend <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (state == IDLE && sel_vld) ovf_pend <= clamp_hit;
            if (state == SHIFT && cnt == 3'd6) ovf <= ovf_pend;
            else                               ovf <= 1'b0;
        end
    end
`else
    assign grant_val = raw_val;
    assign ovf       = 1'b0;
`endif

endmodule
